digit_entry_sequencer: RTL and testbench
========================================

# digit_entry_sequencer

Sequences one handwritten-digit entry from stroke completion to board write during play. It latches the target cell when a stroke finishes, starts the digit predictor, waits for its result with a timeout, and issues exactly one write pulse to the Sudoku solver/board store. Right-click erase requests share the same single write port and are serialised behind any entry in progress. It sits between the stroke-capture block, the predictor, and the solver's write interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000 — max cycles in WAIT for predictor finish (10 ms at 100 MHz)
- COOLDOWN_CYCLES, 16 — idle cycles after any commit/reject/timeout before the next request is accepted

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- game_active  in  1  level; 1 while in play stage
- cell_fixed  in  81  1 = given clue cell, not writable; index row*9+col
- stroke_valid  in  1  one-cycle pulse: stroke complete
- stroke_x, stroke_y  in  4 each  stroke cell column/row, sampled with stroke_valid
- erase_req  in  1  one-cycle pulse: erase request
- erase_x, erase_y  in  4 each  erase cell column/row, sampled with erase_req
- pred_start  out  1  one-cycle pulse to predictor
- pred_finish  in  1  one-cycle pulse from predictor
- pred_digit  in  4  predicted digit, valid with pred_finish
- wr_en  out  1  one-cycle write strobe to solver
- wr_row, wr_col  out  4 each  write target, valid with wr_en
- wr_data  out  4  1..9 digit, 0 = erase
- busy  out  1  1 in any state other than IDLE
- last_result  out  2  00 none, 01 written, 10 rejected, 11 timeout

## Operation
- States: IDLE, START, WAIT, COMMIT, COOL.
- IDLE: with game_active=1, stroke_valid latches (stroke_x, stroke_y) -> START. Else if erase pending or erase_req -> COMMIT with data 0.
- START: pred_start=1 for one cycle -> WAIT; timer cleared.
- WAIT: pred_finish latches pred_digit -> COMMIT. Timer reaches TIMEOUT_CYCLES-1 without finish -> last_result=11 -> COOL.
- COMMIT (one cycle): if coordinate >8, cell_fixed[row*9+col]=1, or digit is not in 1..9 (erase is exempt from the digit check) -> no wr_en, last_result=10. Otherwise wr_en=1 with latched target/data, last_result=01. -> COOL.
- COOL: count COOLDOWN_CYCLES -> IDLE.
- Erase buffer: one entry. erase_req arriving outside IDLE, or together with stroke_valid in IDLE, is stored and overwrites any older pending erase. It executes on the next IDLE cycle that has no stroke_valid.
- stroke_valid outside IDLE is dropped. pred_finish outside WAIT is ignored.
- game_active=0 in any state: next cycle -> IDLE, pending erase cleared, no wr_en or pred_start. last_result holds its value.

## Timing
- Reset: state IDLE; pred_start, wr_en, busy = 0; wr_row, wr_col, wr_data = 0; last_result=00; erase buffer empty; timer 0.
- stroke_valid at cycle t -> pred_start at t+1 -> WAIT from t+2.
- pred_finish at cycle f -> wr_en at f+1 (COMMIT) -> COOL from f+2 -> IDLE at f+2+COOLDOWN_CYCLES.
- Erase in IDLE at cycle e -> wr_en at e+1.
- All outputs are registered. wr_en and pred_start are never high longer than one cycle. wr_en and pred_start are never high in the same cycle.
- Timeout: last_result=11 at cycle t+2+TIMEOUT_CYCLES.
- Reset mid-WAIT: a later pred_finish (after reset) is ignored.

## Structure
- Shared package (sudoku_pkg): state encoding, result codes (RES_NONE/WRITTEN/REJECTED/TIMEOUT), BOARD_N=9, cell index function row*9+col.
- Sub-module entry_timer: loadable down-counter with done flag, shared by WAIT timeout and COOL; width = clog2(max(TIMEOUT_CYCLES, COOLDOWN_CYCLES)).

## Test plan
- Stroke at (3,5) on a free cell, predictor returns 7 after 40 cycles -> pred_start at t+1; wr_en one cycle with row=5, col=3, data=7; last_result=01; busy low after cooldown.
- Stroke on a cell_fixed cell, digit 4 -> no wr_en; last_result=10.
- Predictor silent, TIMEOUT_CYCLES=100 -> last_result=11 at t+102; a late pred_finish is ignored, no wr_en.
- erase_req at (0,8) during WAIT -> digit write first, then after cooldown wr_en with row=8, col=0, data=0. Second erase_req during WAIT -> only the newer erase executes.
- stroke_valid and erase_req in the same IDLE cycle -> stroke sequence runs, erase executes after it.
- game_active drops in WAIT, then rst asserted mid-COOL -> IDLE next cycle; no writes; reset values on all outputs.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku entry path: sequencer states, result codes,
// board geometry and cell indexing.
package sudoku_pkg;

    localparam int unsigned BOARD_N = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_COMMIT,
        ST_COOL
    } entry_state_t;

    typedef enum logic [1:0] {
        RES_NONE     = 2'b00,
        RES_WRITTEN  = 2'b01,
        RES_REJECTED = 2'b10,
        RES_TIMEOUT  = 2'b11
    } result_t;

    // Only meaningful for row, col < BOARD_N; callers gate with coord_ok.
    function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return 7'(row) * 7'(BOARD_N) + 7'(col);
    endfunction

    function automatic logic coord_ok(input logic [3:0] v);
        return v < 4'(BOARD_N);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module entry_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/digit_entry_sequencer.sv
// Sequences one handwritten-digit entry (or a buffered erase) from stroke
// completion through prediction to a single write strobe on the board port.
module digit_entry_sequencer
    import sudoku_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned COOLDOWN_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_active,
    input  logic [80:0] cell_fixed,
    input  logic        stroke_valid,
    input  logic [3:0]  stroke_x,
    input  logic [3:0]  stroke_y,
    input  logic        erase_req,
    input  logic [3:0]  erase_x,
    input  logic [3:0]  erase_y,
    output logic        pred_start,
    input  logic        pred_finish,
    input  logic [3:0]  pred_digit,
    output logic        wr_en,
    output logic [3:0]  wr_row,
    output logic [3:0]  wr_col,
    output logic [3:0]  wr_data,
    output logic        busy,
    output logic [1:0]  last_result
);

    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOLDOWN_CYCLES - 1);

    entry_state_t     state, next_state;
    result_t          last_res;
    logic [3:0]       tgt_row, tgt_col;
    logic             erase_pend;
    logic [3:0]       erase_row, erase_col;
    logic             timer_load, timer_done;
    logic [TMR_W-1:0] timer_value;
    logic             go_commit, commit_erase, commit_ok;
    logic [3:0]       commit_row, commit_col, commit_data;
    logic             set_timeout, erase_take, erase_store;

    entry_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_comb begin
        next_state   = state;
        timer_load   = 1'b0;
        timer_value  = '0;
        go_commit    = 1'b0;
        commit_erase = 1'b0;
        commit_row   = '0;
        commit_col   = '0;
        commit_data  = '0;
        set_timeout  = 1'b0;
        erase_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stroke_valid) begin
                    next_state = ST_START;
                end else if (erase_req || erase_pend) begin
                    // A fresh request supersedes the buffered one.
                    go_commit    = 1'b1;
                    commit_erase = 1'b1;
                    erase_take   = 1'b1;
                    commit_row   = erase_req ? erase_y : erase_row;
                    commit_col   = erase_req ? erase_x : erase_col;
                end
            end
            ST_START: begin
                next_state  = ST_WAIT;
                timer_load  = 1'b1;
                timer_value = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (pred_finish) begin
                    go_commit   = 1'b1;
                    commit_row  = tgt_row;
                    commit_col  = tgt_col;
                    commit_data = pred_digit;
                end else if (timer_done) begin
                    next_state  = ST_COOL;
                    set_timeout = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = COOL_LOAD;
                end
            end
            ST_COMMIT: begin
                next_state  = ST_COOL;
                timer_load  = 1'b1;
                timer_value = COOL_LOAD;
            end
            ST_COOL: begin
                if (timer_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (go_commit) begin
            next_state = ST_COMMIT;
        end
        if (!game_active) begin
            next_state  = ST_IDLE;
            go_commit   = 1'b0;
            set_timeout = 1'b0;
            timer_load  = 1'b0;
            erase_take  = 1'b0;
        end
    end

    // Target is checked as it is latched so wr_en can be registered into COMMIT.
    assign commit_ok = coord_ok(commit_row) && coord_ok(commit_col)
                    && !cell_fixed[cell_index(commit_row, commit_col)]
                    && (commit_erase || (commit_data != '0 && commit_data <= 4'(BOARD_N)));

    assign erase_store = game_active && erase_req && !(state == ST_IDLE && !stroke_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pred_start <= 1'b0;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            last_res   <= RES_NONE;
            tgt_row    <= '0;
            tgt_col    <= '0;
            erase_pend <= 1'b0;
            erase_row  <= '0;
            erase_col  <= '0;
        end else begin
            state      <= next_state;
            pred_start <= (next_state == ST_START);
            wr_en      <= go_commit && commit_ok;
            busy       <= (next_state != ST_IDLE);
            if (go_commit && commit_ok) begin
                wr_row  <= commit_row;
                wr_col  <= commit_col;
                wr_data <= commit_data;
            end
            if (go_commit) begin
                last_res <= commit_ok ? RES_WRITTEN : RES_REJECTED;
            end else if (set_timeout) begin
                last_res <= RES_TIMEOUT;
            end
            if (game_active && state == ST_IDLE && stroke_valid) begin
                tgt_row <= stroke_y;
                tgt_col <= stroke_x;
            end
            if (!game_active) begin
                erase_pend <= 1'b0;
            end else if (erase_store) begin
                erase_pend <= 1'b1;
                erase_row  <= erase_y;
                erase_col  <= erase_x;
            end else if (erase_take) begin
                erase_pend <= 1'b0;
            end
        end
    end

    assign last_result = last_res;

endmodule

// File: tb/tb_digit_entry_sequencer.sv
// Directed bench for digit_entry_sequencer with a timestamp-based reference model.
module tb_digit_entry_sequencer;

    localparam int T   = 100;
    localparam int C   = 16;
    localparam int INF = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst, game_active, stroke_valid, erase_req, pred_finish;
    logic [80:0] cell_fixed;
    logic [3:0]  stroke_x, stroke_y, erase_x, erase_y, pred_digit;
    logic        pred_start, wr_en, busy;
    logic [3:0]  wr_row, wr_col, wr_data;
    logic [1:0]  last_result;

    always #5 clk = ~clk;

    digit_entry_sequencer #(.TIMEOUT_CYCLES(T), .COOLDOWN_CYCLES(C)) dut (
        .clk(clk), .rst(rst), .game_active(game_active), .cell_fixed(cell_fixed),
        .stroke_valid(stroke_valid), .stroke_x(stroke_x), .stroke_y(stroke_y),
        .erase_req(erase_req), .erase_x(erase_x), .erase_y(erase_y),
        .pred_start(pred_start), .pred_finish(pred_finish), .pred_digit(pred_digit),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .busy(busy), .last_result(last_result)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {int cyc; logic [3:0] row; logic [3:0] col; logic [3:0] data;} wr_t;
    wr_t wq[$];
    int  ps_q[$];
    int  lr_cyc = -1;
    int  busy_fall = -1;
    logic [1:0] lr_prev = 2'b00;
    logic busy_prev = 1'b0;

    // Model: requests are accepted at edges k >= m_free; predictor window is [m_lo, m_hi].
    int m_free, m_lo, m_hi;
    logic [3:0] m_row, m_col, m_px, m_py;
    bit m_pend;
    bit e_ps, e_wr, e_busy;
    logic [3:0] e_row, e_col, e_data;
    logic [1:0] e_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_commit(input logic [3:0] r, input logic [3:0] c, input logic [3:0] d,
                            input bit er, input int k);
        bit ok;
        ok = (r < 9) && (c < 9) && (er || (d >= 1 && d <= 9));
        if (ok) ok = !cell_fixed[int'(r) * 9 + int'(c)];
        if (ok) begin
            e_wr = 1; e_row = r; e_col = c; e_data = er ? 4'd0 : d; e_last = 2'b01;
        end else begin
            e_last = 2'b10;
        end
        m_free = k + 2 + C;
    endtask

    task automatic model_step(input int k);
        e_ps = 0;
        e_wr = 0;
        if (rst) begin
            m_free = 0; m_lo = -1; m_hi = -1; m_pend = 0;
            e_row = 0; e_col = 0; e_data = 0; e_last = 0; e_busy = 0;
            return;
        end
        if (!game_active) begin
            m_free = k + 1; m_lo = -1; m_hi = -1; m_pend = 0;
        end else if (k >= m_free) begin
            if (stroke_valid) begin
                m_row = stroke_y; m_col = stroke_x;
                m_lo = k + 2; m_hi = k + 1 + T; m_free = INF; e_ps = 1;
                if (erase_req) begin m_pend = 1; m_px = erase_x; m_py = erase_y; end
            end else if (erase_req) begin
                m_commit(erase_y, erase_x, 4'd0, 1, k);
                m_pend = 0;
            end else if (m_pend) begin
                m_commit(m_py, m_px, 4'd0, 1, k);
                m_pend = 0;
            end
        end else begin
            if (erase_req) begin m_pend = 1; m_px = erase_x; m_py = erase_y; end
            if (m_lo >= 0 && k >= m_lo && k <= m_hi) begin
                if (pred_finish) begin
                    m_commit(m_row, m_col, pred_digit, 0, k);
                    m_lo = -1;
                end else if (k == m_hi) begin
                    e_last = 2'b11; m_free = k + 1 + C; m_lo = -1;
                end
            end
        end
        e_busy = (k + 1 < m_free);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(cyc);
            #1;
            check("outputs", 32'({pred_start, wr_en, wr_row, wr_col, wr_data, busy, last_result}),
                  32'({e_ps, e_wr, e_row, e_col, e_data, e_busy, e_last}));
            if (wr_en) wq.push_back('{cyc, wr_row, wr_col, wr_data});
            if (pred_start) ps_q.push_back(cyc);
            if (last_result != lr_prev) lr_cyc = cyc;
            if (busy_prev && !busy) busy_fall = cyc;
            lr_prev = last_result;
            busy_prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int t_s, t_f, t_e;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wq.delete();
        ps_q.delete();
    endtask

    task automatic stroke(input logic [3:0] x, input logic [3:0] y);
        stroke_valid = 1; stroke_x = x; stroke_y = y; t_s = cyc;
        @(negedge clk);
        stroke_valid = 0;
    endtask

    task automatic finish(input logic [3:0] d);
        pred_finish = 1; pred_digit = d; t_f = cyc;
        @(negedge clk);
        pred_finish = 0;
    endtask

    task automatic erase(input logic [3:0] x, input logic [3:0] y);
        erase_req = 1; erase_x = x; erase_y = y; t_e = cyc;
        @(negedge clk);
        erase_req = 0;
    endtask

    // Wait until busy has stayed low for three cycles, within a cycle budget.
    task automatic settle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            tests++;
            fails++;
            $display("FAIL settle: busy=%0b after %0d cycles, required idle", busy, n);
        end
    endtask

    initial begin
        rst = 1; game_active = 1; cell_fixed = '0;
        stroke_valid = 0; stroke_x = 0; stroke_y = 0;
        erase_req = 0; erase_x = 0; erase_y = 0;
        pred_finish = 0; pred_digit = 0;
        cell_fixed[2 * 9 + 6] = 1'b1;
        cycles(3);
        rst = 0;
        check("reset_outputs", 32'({pred_start, wr_en, wr_row, wr_col, wr_data, busy, last_result}), 32'd0);
        cycles(2);

        // Free cell (row 5, col 3), digit 7 after 40 cycles.
        clear_logs();
        stroke(4'd3, 4'd5);
        cycles(39);
        finish(4'd7);
        settle(100);
        check("t1_pred_start_cycle", ps_q.size() > 0 ? ps_q[0] : -1, t_s + 1);
        check("t1_write_count", wq.size(), 1);
        if (wq.size() > 0) begin
            check("t1_write_cycle", wq[0].cyc, t_f + 1);
            check("t1_write_target", {wq[0].row, wq[0].col, wq[0].data}, {4'd5, 4'd3, 4'd7});
        end
        check("t1_result_cycle", lr_cyc, t_f + 1);
        check("t1_result", last_result, 2'b01);
        check("t1_busy_fall", busy_fall, t_f + 2 + C);

        // Fixed clue cell -> rejected.
        clear_logs();
        stroke(4'd6, 4'd2);
        cycles(5);
        finish(4'd4);
        settle(100);
        check("t2_write_count", wq.size(), 0);
        check("t2_result", last_result, 2'b10);

        // Silent predictor -> timeout, late finish during cooldown ignored.
        clear_logs();
        stroke(4'd1, 4'd0);
        cycles(T + 4);
        finish(4'd2);
        settle(100);
        check("t3_result_cycle", lr_cyc, t_s + 2 + T);
        check("t3_result", last_result, 2'b11);
        check("t3_write_count", wq.size(), 0);

        // Erase buffered during WAIT runs after the digit write.
        clear_logs();
        stroke(4'd1, 4'd1);
        cycles(5);
        erase(4'd0, 4'd8);
        cycles(5);
        finish(4'd9);
        settle(100);
        check("t4_write_count", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t4_first", {wq[0].row, wq[0].col, wq[0].data}, {4'd1, 4'd1, 4'd9});
            check("t4_erase", {wq[1].row, wq[1].col, wq[1].data}, {4'd8, 4'd0, 4'd0});
            check("t4_erase_cycle", wq[1].cyc, t_f + 3 + C);
        end

        // Two erases during WAIT: only the newer one survives.
        clear_logs();
        stroke(4'd2, 4'd2);
        cycles(3);
        erase(4'd2, 4'd2);
        cycles(2);
        erase(4'd4, 4'd4);
        cycles(2);
        finish(4'd3);
        settle(100);
        check("t4b_write_count", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t4b_erase", {wq[1].row, wq[1].col, wq[1].data}, {4'd4, 4'd4, 4'd0});
        end

        // Stroke and erase in the same IDLE cycle.
        clear_logs();
        stroke_valid = 1; stroke_x = 4'd7; stroke_y = 4'd0;
        erase_req = 1; erase_x = 4'd8; erase_y = 4'd8;
        @(negedge clk);
        stroke_valid = 0; erase_req = 0;
        cycles(10);
        finish(4'd5);
        settle(100);
        check("t5_write_count", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t5_first", {wq[0].row, wq[0].col, wq[0].data}, {4'd0, 4'd7, 4'd5});
            check("t5_erase", {wq[1].row, wq[1].col, wq[1].data}, {4'd8, 4'd8, 4'd0});
            check("t5_erase_cycle", wq[1].cyc, t_f + 3 + C);
        end

        // Direct erase in IDLE, out-of-range erase, and illegal digits.
        clear_logs();
        erase(4'd4, 4'd6);
        settle(100);
        check("t6_write_count", wq.size(), 1);
        if (wq.size() == 1) begin
            check("t6_write_cycle", wq[0].cyc, t_e + 1);
            check("t6_target", {wq[0].row, wq[0].col, wq[0].data}, {4'd6, 4'd4, 4'd0});
        end
        clear_logs();
        erase(4'd9, 4'd0);
        settle(100);
        check("t6_range_count", wq.size(), 0);
        check("t6_range_result", last_result, 2'b10);
        stroke(4'd0, 4'd0);
        cycles(3);
        finish(4'd0);
        settle(100);
        check("t6_digit0_result", last_result, 2'b10);
        stroke(4'd8, 4'd7);
        cycles(3);
        finish(4'd10);
        settle(100);
        check("t6_digit10_count", wq.size(), 0);

        // game_active drop in WAIT clears everything, then reset mid-COOL.
        clear_logs();
        stroke(4'd5, 4'd5);
        cycles(3);
        erase(4'd3, 4'd3);
        cycles(2);
        game_active = 0;
        cycles(1);
        check("t7_busy_after_drop", busy, 1'b0);
        cycles(1);
        game_active = 1;
        cycles(5);
        finish(4'd6);
        cycles(3);
        check("t7_write_count", wq.size(), 0);
        check("t7_pred_start_count", ps_q.size(), 1);
        stroke(4'd5, 4'd5);
        cycles(T + 6);
        check("t7_in_cool", {busy, last_result}, {1'b1, 2'b11});
        rst = 1;
        cycles(1);
        check("t7_reset_outputs", 32'({pred_start, wr_en, wr_row, wr_col, wr_data, busy, last_result}), 32'd0);
        rst = 0;
        cycles(1);
        finish(4'd6);
        cycles(5);
        check("t7_late_finish_count", wq.size(), 0);
        check("t7_result_after_reset", last_result, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
